// File: rtl/pwm_multi_shadowed.sv
// Multi-channel PWM generator: one shared edge- or center-aligned counter feeds CHANNELS compare outputs.
// Compare, top and mode settings are double-buffered and only take effect at a period boundary.
module pwm_multi_shadowed #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    d,
    input  logic [1:0]          sel,
    input  logic [CW-1:0]       ch,
    input  logic                mode,
    output logic [WIDTH-1:0]    cnt,
    output logic [CHANNELS-1:0] out,
    output logic                period_end
);

    localparam logic [1:0] SEL_CMP   = 2'b01;
    localparam logic [1:0] SEL_TOP   = 2'b10;
    localparam logic [1:0] SEL_CNT   = 2'b11;
    localparam logic       MODE_EDGE = 1'b0;
    localparam logic [0:0] DIR_UP    = 1'b0;
    localparam logic [0:0] DIR_DOWN  = 1'b1;

    logic [WIDTH-1:0]                cnt_q, cnt_d;
    logic [0:0]                      dir_q, dir_d;
    logic [WIDTH-1:0]                top_act_q, top_act_d;
    logic [WIDTH-1:0]                top_shd_q, top_shd_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  cmp_act_q, cmp_act_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  cmp_shd_q, cmp_shd_d;
    logic                            mode_act_q, mode_act_d;
    logic [CHANNELS-1:0]             out_q, out_d;
    logic                            period_end_q, period_end_d;
    logic                            boundary;
    logic                            ch_valid;

    assign ch_valid = (int'({1'b0, ch}) < CHANNELS);

    // Counter sequencing. A direct load overrides counting and suppresses the boundary.
    // top_act==0 pins the counter at 0 with a boundary every cycle, whatever the mode.
    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        boundary = 1'b0;
        if (sel == SEL_CNT) begin
            cnt_d = d;
        end else if (top_act_q == '0) begin
            cnt_d    = '0;
            boundary = 1'b1;
        end else if (mode_act_q == MODE_EDGE) begin
            if (cnt_q >= top_act_q) begin
                cnt_d    = '0;
                boundary = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else if (dir_q == DIR_UP) begin
            if (cnt_q >= top_act_q) begin
                cnt_d = cnt_q - WIDTH'(1);
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else begin
            if (cnt_q == '0) begin
                cnt_d    = WIDTH'(1);
                boundary = 1'b1;
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
        // Every boundary re-arms upward counting, so a switch into center mode starts rising.
        if (boundary) begin
            dir_d = DIR_UP;
        end
    end

    // Shadow writes, then transfer to the active set at a boundary. Using the *_d shadow values
    // gives the same-cycle bypass; mode is rewritten every cycle so its shadow is the mode input.
    always_comb begin
        top_shd_d  = top_shd_q;
        cmp_shd_d  = cmp_shd_q;
        top_act_d  = top_act_q;
        cmp_act_d  = cmp_act_q;
        mode_act_d = mode_act_q;
        if (sel == SEL_TOP) begin
            top_shd_d = d;
        end
        if ((sel == SEL_CMP) && ch_valid) begin
            cmp_shd_d[ch] = d;
        end
        if (boundary) begin
            top_act_d  = top_shd_d;
            cmp_act_d  = cmp_shd_d;
            mode_act_d = mode;
        end
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            out_d[i] = (cnt_q < cmp_act_q[i]);
        end
        period_end_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            top_act_q    <= '0;
            top_shd_q    <= '0;
            cmp_act_q    <= '0;
            cmp_shd_q    <= '0;
            mode_act_q   <= MODE_EDGE;
            out_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            top_act_q    <= top_act_d;
            top_shd_q    <= top_shd_d;
            cmp_act_q    <= cmp_act_d;
            cmp_shd_q    <= cmp_shd_d;
            mode_act_q   <= mode_act_d;
            out_q        <= out_d;
            period_end_q <= period_end_d;
        end
    end

    assign cnt        = cnt_q;
    assign out        = out_q;
    assign period_end = period_end_q;

endmodule

// File: tb/tb_pwm_multi_shadowed.sv
// Self-checking bench for pwm_multi_shadowed: vector table, directed period/duty sequences,
// and randomized traffic against a cycle-level reference model of the counting rules.
module tb_pwm_multi_shadowed;

    localparam int W   = 8;
    localparam int NCH = 5;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   d;
    logic [1:0]     sel;
    logic [2:0]     ch;
    logic           mode;
    logic [W-1:0]   cnt;
    logic [NCH-1:0] out;
    logic           period_end;

    int checks   = 0;
    int failures = 0;

    pwm_multi_shadowed #(.WIDTH(W), .CHANNELS(NCH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d),
        .sel        (sel),
        .ch         (ch),
        .mode       (mode),
        .cnt        (cnt),
        .out        (out),
        .period_end (period_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int           m_cnt;
    bit           m_up;
    int           m_top_act;
    int           m_top_shd;
    int           m_cmp_act [NCH];
    int           m_cmp_shd [NCH];
    bit           m_mode_act;
    logic [NCH-1:0] m_out;
    bit           m_pe;

    task automatic modelReset();
        m_cnt = 0; m_up = 1; m_top_act = 0; m_top_shd = 0; m_mode_act = 0;
        m_out = '0; m_pe = 0;
        for (int i = 0; i < NCH; i++) begin
            m_cmp_act[i] = 0;
            m_cmp_shd[i] = 0;
        end
    endtask

    // One clock of the behavioural rules: outputs from the present count, then count/transfer.
    task automatic modelStep(input int s, input int dv, input int c, input int m);
        int nxt;
        bit bnd;
        for (int i = 0; i < NCH; i++) m_out[i] = (m_cnt < m_cmp_act[i]);
        bnd = 0;
        nxt = m_cnt;
        if (s == 3) nxt = dv;
        else if (m_top_act == 0) begin nxt = 0; bnd = 1; end
        else if (!m_mode_act) begin
            if (m_cnt >= m_top_act) begin nxt = 0; bnd = 1; end
            else nxt = m_cnt + 1;
        end else if (m_up) begin
            if (m_cnt >= m_top_act) begin nxt = m_cnt - 1; m_up = 0; end
            else nxt = m_cnt + 1;
        end else begin
            if (m_cnt == 0) begin nxt = 1; bnd = 1; end
            else nxt = m_cnt - 1;
        end
        if (s == 1 && c < NCH) m_cmp_shd[c] = dv;
        if (s == 2) m_top_shd = dv;
        if (bnd) begin
            m_up = 1;
            m_top_act = m_top_shd;
            for (int i = 0; i < NCH; i++) m_cmp_act[i] = m_cmp_shd[i];
            m_mode_act = (m != 0);
        end
        m_cnt = nxt;
        m_pe  = bnd;
    endtask

    function automatic int expLen(input int top, input int m);
        if (top == 0) return 1;
        return (m != 0) ? 2 * top : top + 1;
    endfunction

    // High samples per period: enumerate the count values one period visits.
    function automatic int expHighs(input int top, input int cmp, input int m);
        int n = 0;
        if (top == 0) return (cmp > 0) ? 1 : 0;
        for (int v = 0; v <= top; v++) if (v < cmp) n++;
        if (m != 0) for (int v = top - 1; v >= 1; v--) if (v < cmp) n++;
        return n;
    endfunction

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int exp_cnt, input int exp_out, input int exp_pe);
        checkValue({name, ".cnt"}, int'(cnt), exp_cnt);
        checkValue({name, ".out"}, int'(out), exp_out);
        checkValue({name, ".period_end"}, int'(period_end), exp_pe);
    endtask

    task automatic applyStimulus(input int s, input int dv, input int c, input int m);
        sel  = 2'(s);
        d    = 8'(dv);
        ch   = 3'(c);
        mode = 1'(m);
        @(posedge clk);
        modelStep(s, dv, c, m);
        #1;
    endtask

    task automatic stepChecked(input int s, input int dv, input int c, input int m);
        applyStimulus(s, dv, c, m);
        checkOutput("step", m_cnt, int'(m_out), int'(m_pe));
    endtask

    // From the next period_end sample, count samples to the following one and highs on channel chn.
    task automatic measurePeriod(input int chn, input int m, output int len, output int highs);
        int guard = 0;
        len = 0;
        highs = 0;
        while (period_end !== 1'b1 && guard < 700) begin
            stepChecked(0, 0, 0, m);
            guard++;
        end
        if (guard >= 700) begin
            checks++; failures++;
            $display("[TB] FAIL period_start_timeout: got %0d cycles without period_end, expected a pulse", guard);
            return;
        end
        do begin
            stepChecked(0, 0, 0, m);
            len++;
            if (out[chn]) highs++;
        end while (period_end !== 1'b1 && len < 700);
    endtask

    task automatic waitModelCnt(input int target, input int m);
        int guard = 0;
        while (m_cnt != target && guard < 700) begin
            stepChecked(0, 0, 0, m);
            guard++;
        end
        if (guard >= 700) begin
            checks++; failures++;
            $display("[TB] FAIL wait_cnt_timeout: got %0d cycles, expected cnt=%0d", guard, target);
        end
    endtask

    typedef struct {
        int s; int dv; int c; int m;
        int e_cnt; int e_out; int e_pe;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int len, highs, r, s, dv, c, rmode;

        rst_n = 1'b0; sel = '0; d = '0; ch = '0; mode = 1'b0;
        modelReset();
        #12;
        checkOutput("reset", 0, 0, 0);
        #10 rst_n = 1'b1;

        // Edge mode: top=9 lands immediately (top_act=0 means boundary every cycle), cmp0=3 next wrap.
        vecs[0] = '{2, 9, 0, 0, 0, 0, 1};
        vecs[1] = '{1, 3, 0, 0, 1, 0, 0};
        for (int i = 2; i <= 9; i++) vecs[i] = '{0, 0, 0, 0, i, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 1};
        vecs[11] = '{0, 0, 0, 0, 1, 1, 0};
        vecs[12] = '{0, 0, 0, 0, 2, 1, 0};
        vecs[13] = '{0, 0, 0, 0, 3, 1, 0};
        vecs[14] = '{0, 0, 0, 0, 4, 0, 0};
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].s, vecs[i].dv, vecs[i].c, vecs[i].m);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_out, vecs[i].e_pe);
        end

        // Mid-period compare write at cnt=4 only shows up after the wrap.
        stepChecked(1, 7, 0, 0);
        measurePeriod(0, 0, len, highs);
        checkValue("shadow_len", len, expLen(9, 0));
        checkValue("shadow_highs", highs, expHighs(9, 7, 0));

        // Limits: cmp=0 never high, cmp>top always high, out-of-range channel writes dropped.
        stepChecked(1, 10, 3, 0);
        stepChecked(1, 0, 2, 0);
        stepChecked(1, 8, 5, 0);
        stepChecked(1, 9, 6, 0);
        measurePeriod(3, 0, len, highs);
        measurePeriod(3, 0, len, highs);
        checkValue("full_len", len, expLen(9, 0));
        checkValue("full_highs", highs, expHighs(9, 10, 0));
        measurePeriod(2, 0, len, highs);
        checkValue("zero_highs", highs, expHighs(9, 0, 0));

        // Center mode, top=4, cmp1=2.
        stepChecked(2, 4, 0, 1);
        stepChecked(1, 2, 1, 1);
        measurePeriod(1, 1, len, highs);
        measurePeriod(1, 1, len, highs);
        checkValue("center_len", len, expLen(4, 1));
        checkValue("center_highs", highs, expHighs(4, 2, 1));

        // Direct load on what would have been the wrap cycle: no boundary, then wrap from 20.
        stepChecked(2, 9, 0, 0);
        measurePeriod(0, 0, len, highs);
        waitModelCnt(9, 0);
        stepChecked(3, 20, 0, 0);
        checkOutput("load", 20, int'(m_out), 0);
        stepChecked(0, 0, 0, 0);
        checkOutput("load_wrap", 0, int'(m_out), 1);

        // Asynchronous reset in the middle of a period.
        waitModelCnt(6, 0);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, 0, 0);
        modelReset();
        #7 rst_n = 1'b1;
        checkOutput("reset_hold", 0, 0, 0);

        // Top written in the boundary cycle applies to the very next period.
        stepChecked(2, 9, 0, 0);
        waitModelCnt(9, 0);
        stepChecked(2, 5, 0, 0);
        measurePeriod(0, 0, len, highs);
        checkValue("bypass_len", len, expLen(5, 0));

        // Full-range top: wrap must come from the compare, not from overflow.
        stepChecked(2, 255, 0, 0);
        stepChecked(1, 200, 0, 0);
        measurePeriod(0, 0, len, highs);
        measurePeriod(0, 0, len, highs);
        checkValue("max_len", len, expLen(255, 0));
        checkValue("max_highs", highs, expHighs(255, 200, 0));

        // Randomized traffic against the model.
        stepChecked(2, 6, 0, 0);
        measurePeriod(0, 0, len, highs);
        rmode = 0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 59) == 0) rmode = 1 - rmode;
            r = int'($urandom_range(0, 19));
            if (r < 12) s = 0;
            else if (r < 16) s = 1;
            else if (r < 19) s = 2;
            else s = 3;
            case (s)
                1: dv = int'($urandom_range(0, 14));
                2: dv = int'($urandom_range(0, 10));
                3: dv = int'($urandom_range(0, 20));
                default: dv = int'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 49) == 0) dv = int'($urandom_range(0, 255));
            c = int'($urandom_range(0, 7));
            stepChecked(s, dv, c, rmode);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
